// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver: multiplexed LED matrix scanner with tear-free pattern load, row blanking, blink and frame strobe
module led_matrix_scan_driver #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 blink_en,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [ROWS*COLS-1:0] pat_data,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 frame_done
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_t;
  scan_t st;
  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [RW-1:0] row_idx, row_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic blink_phase, phase_nxt, pend_v, slot_wrap, frame_wrap, fb, lit, accept, apply;
  logic [ROWS*COLS-1:0] active, pending;
  logic [ROWS-1:0] row_sel, rows_nxt;
  logic [COLS-1:0] row_pat, cols_nxt;
  assign pat_ready = !pend_v;
  // scan phase classification, counter advance, blink tracking and next registered outputs
  always_comb begin
    row_sel = '0;
    row_pat = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_sel[r] = row_idx == RW'(r);
      row_pat = row_idx == RW'(r) ? active[r*COLS +: COLS] : row_pat;
    end
    st = !enable ? IDLE : slot_cnt < SW'(BLANK_CYCLES) ? BLANK : DRIVE;
    slot_wrap = slot_cnt == SW'(SCAN_DIV - 1);
    fb = enable && slot_wrap && row_idx == RW'(ROWS - 1);
    slot_nxt = !enable || slot_wrap ? '0 : slot_cnt + 1'b1;
    row_nxt = !enable || fb ? '0 : slot_wrap ? row_idx + 1'b1 : row_idx;
    frame_wrap = frame_cnt == FW'(BLINK_FRAMES - 1);
    frame_nxt = !blink_en ? '0 : fb ? (frame_wrap ? '0 : frame_cnt + 1'b1) : frame_cnt;
    phase_nxt = blink_en && (blink_phase ^ (fb && frame_wrap));
    lit = st == DRIVE && !(blink_en && blink_phase);
    rows_nxt = lit ? row_sel : '0;
    cols_nxt = lit ? ~row_pat : '1;
    accept = pat_valid && !pend_v;
    apply = pend_v && (fb || !enable);
  end
  // state, pattern double-buffer and registered pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      row_idx <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
      pend_v <= 1'b0;
      pending <= '0;
      active <= '0;
      rows <= '0;
      cols <= '1;
      frame_done <= 1'b0;
    end else begin
      slot_cnt <= slot_nxt;
      row_idx <= row_nxt;
      frame_cnt <= frame_nxt;
      blink_phase <= phase_nxt;
      rows <= rows_nxt;
      cols <= cols_nxt;
      frame_done <= fb;
      if (accept) begin
        pend_v <= 1'b1;
        pending <= pat_data;
      end else if (apply) begin
        pend_v <= 1'b0;
        active <= pending;
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb_led_matrix_scan_driver: directed scan/handshake/blink test against a frame-position model
module tb_led_matrix_scan_driver;
  localparam int R = 3, C = 3, SD = 8, BC = 2, BF = 2;
  logic clk = 0, reset = 1, enable = 0, blink_en = 0, pat_valid = 0;
  logic [8:0] pat_data = '0;
  logic pat_ready, frame_done;
  logic [2:0] rows, cols;
  int total = 0, bad = 0;
  led_matrix_scan_driver #(.ROWS(R), .COLS(C), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .blink_en(blink_en), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .pat_data(pat_data), .rows(rows), .cols(cols), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  // model: position in the enabled scan and count of frames finished while blinking
  int m_pos = 0, m_bfr = 0, m_slot, m_row;
  bit m_fb, m_dark, m_pv = 0;
  logic [8:0] m_active = '0, m_pend = '0, m_tmp;
  logic [2:0] e_rows = '0, e_cols = '1;
  logic e_fd = 0, e_ready = 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_pos = 0; m_bfr = 0; m_pv = 0; m_active = '0;
      e_rows = '0; e_cols = '1; e_fd = 0;
    end else begin
      m_slot = m_pos % SD;
      m_row = (m_pos / SD) % R;
      m_fb = enable && m_slot == SD - 1 && m_row == R - 1;
      m_dark = blink_en && ((m_bfr / BF) % 2 == 1);
      m_tmp = m_active >> (m_row * C);
      e_rows = enable && m_slot >= BC && !m_dark ? 3'(1 << m_row) : 3'b000;
      e_cols = enable && m_slot >= BC && !m_dark ? ~m_tmp[2:0] : 3'b111;
      e_fd = m_fb;
      if (pat_valid && !m_pv) begin
        m_pend = pat_data; m_pv = 1;
      end else if (m_pv && (m_fb || !enable)) begin
        m_active = m_pend; m_pv = 0;
      end
      m_bfr = !blink_en ? 0 : m_fb ? m_bfr + 1 : m_bfr;
      m_pos = enable ? m_pos + 1 : 0;
    end
    e_ready = !m_pv;
  end
  always @(negedge clk) begin
    chk("m_rows", 32'(rows), 32'(e_rows));
    chk("m_cols", 32'(cols), 32'(e_cols));
    chk("m_frame_done", 32'(frame_done), 32'(e_fd));
    chk("m_pat_ready", 32'(pat_ready), 32'(e_ready));
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    step(2);
    chk("rst_rows", 32'(rows), 0); chk("rst_cols", 32'(cols), 7);
    chk("rst_ready", 32'(pat_ready), 1); chk("rst_fd", 32'(frame_done), 0);
    reset = 0; pat_valid = 1; pat_data = 9'h1FF;
    step(1); chk("idle_load_busy", 32'(pat_ready), 0); pat_valid = 0;
    step(1); chk("idle_load_done", 32'(pat_ready), 1); enable = 1;
    step(2); chk("t1_blank_rows", 32'(rows), 0); chk("t1_blank_cols", 32'(cols), 7);
    step(1); chk("t1_r0_rows", 32'(rows), 1); chk("t1_r0_cols", 32'(cols), 0);
    step(8); chk("t1_r1_rows", 32'(rows), 2);
    step(8); chk("t1_r2_rows", 32'(rows), 4);
    step(4); chk("t1_fd_early", 32'(frame_done), 0);
    step(1); chk("t1_fd", 32'(frame_done), 1); chk("t1_fb_rows", 32'(rows), 4);
    step(1); chk("t1_fd_once", 32'(frame_done), 0); chk("t1_next_rows", 32'(rows), 0);
    step(5); pat_valid = 1; pat_data = 9'h010;
    step(1); chk("t2_busy", 32'(pat_ready), 0); pat_valid = 0; pat_data = 9'h155;
    step(16); chk("t2_busy_fb", 32'(pat_ready), 0);
    step(1); chk("t2_free", 32'(pat_ready), 1);
    step(3); chk("t2_r0_rows", 32'(rows), 1); chk("t2_r0_cols", 32'(cols), 7);
    step(8); chk("t2_r1_rows", 32'(rows), 2); chk("t2_r1_cols", 32'(cols), 5);
    step(12); pat_valid = 1; pat_data = 9'h001;
    step(1); chk("t3_busy", 32'(pat_ready), 0); pat_data = 9'h100;
    step(11); chk("t3_old_rows", 32'(rows), 2); chk("t3_old_cols", 32'(cols), 5);
    step(12); chk("t3_stall", 32'(pat_ready), 0);
    step(1); chk("t3_free", 32'(pat_ready), 1);
    step(1); chk("t3_second", 32'(pat_ready), 0); pat_valid = 0;
    step(2); chk("t3_new_rows", 32'(rows), 1); chk("t3_new_cols", 32'(cols), 6);
    step(21); pat_valid = 1; pat_data = 9'h1FF;
    step(1); pat_valid = 0;
    step(23); blink_en = 1;
    step(48); chk("t4_fd", 32'(frame_done), 1);
    step(3); chk("t4_dark_rows", 32'(rows), 0); chk("t4_dark_cols", 32'(cols), 7);
    step(48); chk("t4_lit_rows", 32'(rows), 1); chk("t4_lit_cols", 32'(cols), 0);
    step(56); chk("t4_dark2_rows", 32'(rows), 0);
    step(1); blink_en = 0;
    step(1); chk("t4_unblink_rows", 32'(rows), 2); chk("t4_unblink_cols", 32'(cols), 0);
    step(23); chk("t5_drive_rows", 32'(rows), 2); enable = 0;
    step(1); chk("t5_off_rows", 32'(rows), 0); chk("t5_off_cols", 32'(cols), 7); chk("t5_off_fd", 32'(frame_done), 0);
    step(1); pat_valid = 1; pat_data = 9'h038;
    step(1); chk("t5_busy", 32'(pat_ready), 0); pat_valid = 0;
    step(1); chk("t5_free", 32'(pat_ready), 1);
    step(2); enable = 1;
    step(3); chk("t5_r0_rows", 32'(rows), 1); chk("t5_r0_cols", 32'(cols), 7);
    step(8); chk("t5_r1_rows", 32'(rows), 2); chk("t5_r1_cols", 32'(cols), 0);
    pat_valid = 1; pat_data = 9'h1FF;
    step(1); chk("t6_busy", 32'(pat_ready), 0); pat_valid = 0;
    step(1); reset = 1;
    step(1); chk("t6_rows", 32'(rows), 0); chk("t6_cols", 32'(cols), 7); chk("t6_ready", 32'(pat_ready), 1);
    reset = 0;
    step(3); chk("t6_r0_rows", 32'(rows), 1); chk("t6_r0_cols", 32'(cols), 7);
    step(3); pat_valid = 1; pat_data = 9'h007;
    step(1); pat_valid = 0;
    step(4); chk("t6_r1_cols", 32'(cols), 7);
    step(16); chk("t6_new_rows", 32'(rows), 1); chk("t6_new_cols", 32'(cols), 0);
    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
